control_sequencer: RTL

Hardwired control unit for the datapath. It steps each instruction through states T0–T6. In each state it drives the one-hot datapath control strobes (PCout, MARin, Zlowout, MDRin, IRin, Yin, HIin, etc.) that a bench would otherwise sequence by hand. It also decodes the IR opcode to select the ALU operation and the Gra/Grb/Grc register-select lines. It sits directly upstream of the datapath and consumes only the IR contents.

---
 rtl/ctl_pkg.sv | 73 +++++++
 rtl/ctl_decode.sv | 35 +++
 rtl/control_sequencer.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ctl_pkg.sv
// Shared types for the hardwired control sequencer: state encoding, opcode/ALU codes,
// instruction classes and the bundle of datapath strobes.
package ctl_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_T0,
    S_T1,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CLS_ALU,
    CLS_MULDIV,
    CLS_NOP,
    CLS_HALT,
    CLS_ILLEGAL
  } op_class_t;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_AND  = 5'b00101;
  localparam logic [4:0] OP_OR   = 5'b00110;
  localparam logic [4:0] OP_SHR  = 5'b00111;
  localparam logic [4:0] OP_SHRA = 5'b01000;
  localparam logic [4:0] OP_SHL  = 5'b01001;
  localparam logic [4:0] OP_ROR  = 5'b01010;
  localparam logic [4:0] OP_ROL  = 5'b01011;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd4;
  localparam logic [3:0] ALU_SHRA = 4'd5;
  localparam logic [3:0] ALU_SHL  = 4'd6;
  localparam logic [3:0] ALU_ROR  = 4'd7;
  localparam logic [3:0] ALU_ROL  = 4'd8;
  localparam logic [3:0] ALU_MUL  = 4'd9;
  localparam logic [3:0] ALU_DIV  = 4'd10;

  typedef struct packed {
    logic pc_out;
    logic mar_in;
    logic inc_pc;
    logic pc_in;
    logic z_in;
    logic zlow_out;
    logic zhigh_out;
    logic read;
    logic mdr_in;
    logic mdr_out;
    logic ir_in;
    logic y_in;
    logic hi_in;
    logic lo_in;
    logic gra;
    logic grb;
    logic grc;
    logic r_in;
    logic r_out;
  } strobes_t;

endpackage

// File: rtl/ctl_decode.sv
// Combinational opcode decoder: maps the IR opcode field to an instruction class
// and the ALU function code used during T4.
module ctl_decode
  import ctl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int AOPW = 4
) (
  input  logic [OPW-1:0]  opcode,
  output op_class_t       op_class,
  output logic [AOPW-1:0] alu_op
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    alu_op   = '0;
    case (opcode)
      OP_ADD:  begin op_class = CLS_ALU;    alu_op = AOPW'(ALU_ADD);  end
      OP_SUB:  begin op_class = CLS_ALU;    alu_op = AOPW'(ALU_SUB);  end
      OP_AND:  begin op_class = CLS_ALU;    alu_op = AOPW'(ALU_AND);  end
      OP_OR:   begin op_class = CLS_ALU;    alu_op = AOPW'(ALU_OR);   end
      OP_SHR:  begin op_class = CLS_ALU;    alu_op = AOPW'(ALU_SHR);  end
      OP_SHRA: begin op_class = CLS_ALU;    alu_op = AOPW'(ALU_SHRA); end
      OP_SHL:  begin op_class = CLS_ALU;    alu_op = AOPW'(ALU_SHL);  end
      OP_ROR:  begin op_class = CLS_ALU;    alu_op = AOPW'(ALU_ROR);  end
      OP_ROL:  begin op_class = CLS_ALU;    alu_op = AOPW'(ALU_ROL);  end
      OP_MUL:  begin op_class = CLS_MULDIV; alu_op = AOPW'(ALU_MUL);  end
      OP_DIV:  begin op_class = CLS_MULDIV; alu_op = AOPW'(ALU_DIV);  end
      OP_NOP:  op_class = CLS_NOP;
      OP_HALT: op_class = CLS_HALT;
      default: op_class = CLS_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control unit stepping each instruction through T0-T6 with registered strobes.
// Define MEM_WAIT_EN to hold T1 (Read/MDRin high) until mem_ready signals the read is done.
module control_sequencer
  import ctl_pkg::*;
#(
  parameter int OPW  = 5,
  parameter int AOPW = 4
) (
  input  logic            clock,
  input  logic            clear,
  input  logic            run,
  input  logic [31:0]     ir,
  input  logic            mem_ready,
  output logic            PCout,
  output logic            MARin,
  output logic            IncPC,
  output logic            PCin,
  output logic            Zin,
  output logic            Zlowout,
  output logic            ZHighout,
  output logic            Read,
  output logic            MDRin,
  output logic            MDRout,
  output logic            IRin,
  output logic            Yin,
  output logic            HIin,
  output logic            LOin,
  output logic            Gra,
  output logic            Grb,
  output logic            Grc,
  output logic            Rin,
  output logic            Rout,
  output logic [AOPW-1:0] alu_op,
  output logic            halted,
  output logic            illegal
);

  state_t          state, next_state, boundary_state;
  strobes_t        strb, next_strb;
  op_class_t       op_class;
  logic [AOPW-1:0] dec_alu_op, next_alu_op;
  logic            unused_inputs;

  assign unused_inputs  = ^{ir[31-OPW:0], mem_ready};
  assign boundary_state = run ? S_T0 : S_IDLE;

  ctl_decode #(.OPW(OPW), .AOPW(AOPW)) u_decode (
    .opcode   (ir[31 -: OPW]),
    .op_class (op_class),
    .alu_op   (dec_alu_op)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: if (run) next_state = S_T0;
      S_T0:   next_state = S_T1;
      S_T1: begin
`ifdef MEM_WAIT_EN
        if (mem_ready) next_state = S_T2;
`else
        next_state = S_T2;
`endif
      end
      S_T2: begin
        case (op_class)
          CLS_HALT:             next_state = S_HALT;
          CLS_NOP, CLS_ILLEGAL: next_state = boundary_state;
          default:              next_state = S_T3;
        endcase
      end
      S_T3:   next_state = S_T4;
      S_T4:   next_state = S_T5;
      S_T5:   next_state = (op_class == CLS_MULDIV) ? S_T6 : boundary_state;
      S_T6:   next_state = boundary_state;
      S_HALT: next_state = S_HALT;
      default: next_state = S_IDLE;
    endcase
  end

  // Strobes are computed for the state being entered so they appear right after the edge.
  always_comb begin
    next_strb   = '0;
    next_alu_op = '0;
    case (next_state)
      S_T0: begin
        next_strb.pc_out = 1'b1;
        next_strb.mar_in = 1'b1;
        next_strb.inc_pc = 1'b1;
        next_strb.z_in   = 1'b1;
      end
      S_T1: begin
        next_strb.zlow_out = 1'b1;
        next_strb.pc_in    = 1'b1;
        next_strb.read     = 1'b1;
        next_strb.mdr_in   = 1'b1;
      end
      S_T2: begin
        next_strb.mdr_out = 1'b1;
        next_strb.ir_in   = 1'b1;
      end
      S_T3: begin
        next_strb.grb   = 1'b1;
        next_strb.r_out = 1'b1;
        next_strb.y_in  = 1'b1;
      end
      S_T4: begin
        next_strb.grc   = 1'b1;
        next_strb.r_out = 1'b1;
        next_strb.z_in  = 1'b1;
        next_alu_op     = dec_alu_op;
      end
      S_T5: begin
        next_strb.zlow_out = 1'b1;
        if (op_class == CLS_MULDIV) begin
          next_strb.lo_in = 1'b1;
        end else begin
          next_strb.gra  = 1'b1;
          next_strb.r_in = 1'b1;
        end
      end
      S_T6: begin
        next_strb.zhigh_out = 1'b1;
        next_strb.hi_in     = 1'b1;
      end
      default: next_strb = '0;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= S_IDLE;
      strb    <= '0;
      alu_op  <= '0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      state  <= next_state;
      strb   <= next_strb;
      alu_op <= next_alu_op;
      if (state == S_T2 && op_class == CLS_HALT)    halted  <= 1'b1;
      if (state == S_T2 && op_class == CLS_ILLEGAL) illegal <= 1'b1;
    end
  end

  assign PCout    = strb.pc_out;
  assign MARin    = strb.mar_in;
  assign IncPC    = strb.inc_pc;
  assign PCin     = strb.pc_in;
  assign Zin      = strb.z_in;
  assign Zlowout  = strb.zlow_out;
  assign ZHighout = strb.zhigh_out;
  assign Read     = strb.read;
  assign MDRin    = strb.mdr_in;
  assign MDRout   = strb.mdr_out;
  assign IRin     = strb.ir_in;
  assign Yin      = strb.y_in;
  assign HIin     = strb.hi_in;
  assign LOin     = strb.lo_in;
  assign Gra      = strb.gra;
  assign Grb      = strb.grb;
  assign Grc      = strb.grc;
  assign Rin      = strb.r_in;
  assign Rout     = strb.r_out;

endmodule
